acc_wb_mailbox: RTL

Wishbone slave that terminates the SoC's accelerator port (the `acc` slave of the data-bus mux) and converts CPU register accesses into two streaming FIFOs toward the SNN accelerator. TX is CPU→accelerator and RX is accelerator→CPU. It also provides a status register, a control register (start pulse, flush, interrupt enable) and a level interrupt. It generates the `ack`/`rdt` that the mux returns to SERV.

---
 rtl/acc_wb_mailbox_if.sv | 19 +
 rtl/acc_wb_mailbox.sv | 127 ++++++++++++
 2 files changed

// File: rtl/acc_wb_mailbox_if.sv
// Wishbone slave-side bus bundle between the data-bus mux and the accelerator mailbox.
interface acc_wb_mailbox_if;
  logic [31:0] i_wb_adr;
  logic [31:0] i_wb_dat;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc,
    input  o_wb_rdt, o_wb_ack
  );

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc,
    output o_wb_rdt, o_wb_ack
  );
endinterface

// File: rtl/acc_wb_mailbox.sv
// Wishbone register window onto two streaming FIFOs (TX to the SNN accelerator, RX back to the CPU)
// with status/control registers, a start pulse and a level interrupt.
module acc_wb_mailbox #(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  acc_wb_mailbox_if.slave bus,
  output logic [DW-1:0]   o_tx_data,
  output logic            o_tx_valid,
  input  logic            i_tx_ready,
  input  logic [DW-1:0]   i_rx_data,
  input  logic            i_rx_valid,
  output logic            o_rx_ready,
  output logic            o_start,
  output logic            o_irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DW-1:0] tx_mem [DEPTH];
  logic [DW-1:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic          tx_ovf, rx_udf, irq_en;

  logic [1:0]  sel;
  logic        take, tx_wr, rx_rd, ctrl_wr, flush;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic [31:0] rd_data;
  logic        unused_adr;

  // A cyc still high during its own ack cycle must not start a second access.
  assign sel     = bus.i_wb_adr[3:2];
  assign take    = bus.i_wb_cyc & ~bus.o_wb_ack;
  assign tx_wr   = take &  bus.i_wb_we & (sel == 2'd0);
  assign rx_rd   = take & ~bus.i_wb_we & (sel == 2'd1);
  assign ctrl_wr = take &  bus.i_wb_we & (sel == 2'd3);
  assign flush   = ctrl_wr & bus.i_wb_dat[1];

  assign tx_full  = (tx_cnt == FULL);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL);
  assign rx_empty = (rx_cnt == '0);

  // A full TX still accepts a CPU word when the accelerator frees a slot in the same cycle.
  assign tx_pop  = ~tx_empty & i_tx_ready;
  assign tx_push = tx_wr & (~tx_full | tx_pop);
  assign rx_push = i_rx_valid & ~rx_full;
  assign rx_pop  = rx_rd & ~rx_empty;

  assign o_tx_data  = tx_mem[tx_rp];
  assign o_tx_valid = ~tx_empty;
  assign o_rx_ready = ~rx_full;
  assign o_irq      = irq_en & ~rx_empty;
  assign unused_adr = ^{bus.i_wb_adr[31:4], bus.i_wb_adr[1:0]};

  always_comb begin
    rd_data = '0;
    case (sel)
      2'd0: rd_data = '0;
      2'd1: rd_data = rx_empty ? '0 : rx_mem[rx_rp];
      2'd2: rd_data = {7'b0, irq_en, 8'(rx_cnt), 8'(tx_cnt), 2'b0,
                       rx_udf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full};
      default: rd_data = {29'b0, irq_en, 2'b0};
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.i_wb_dat;
    if (rx_push) rx_mem[rx_wp] <= i_rx_data;
  end

  // Flush overrides every same-cycle push and pop on both FIFOs.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else if (flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_push & ~tx_pop)      tx_cnt <= tx_cnt + 1'b1;
      else if (~tx_push & tx_pop) tx_cnt <= tx_cnt - 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_push & ~rx_pop)      rx_cnt <= rx_cnt + 1'b1;
      else if (~rx_push & rx_pop) rx_cnt <= rx_cnt - 1'b1;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      bus.o_wb_ack <= 1'b0;
      bus.o_wb_rdt <= '0;
      o_start      <= 1'b0;
      irq_en       <= 1'b0;
      tx_ovf       <= 1'b0;
      rx_udf       <= 1'b0;
    end else begin
      bus.o_wb_ack <= take;
      if (take) bus.o_wb_rdt <= rd_data;
      o_start <= ctrl_wr & bus.i_wb_dat[0];
      if (ctrl_wr) irq_en <= bus.i_wb_dat[2];
      if (ctrl_wr & bus.i_wb_dat[3]) begin
        tx_ovf <= 1'b0;
        rx_udf <= 1'b0;
      end else begin
        if (tx_wr & tx_full & ~tx_pop) tx_ovf <= 1'b1;
        if (rx_rd & rx_empty)          rx_udf <= 1'b1;
      end
    end
  end
endmodule
